// File: rtl/accel_ctrl_mc_pkg.sv
// accel_ctrl_mc_pkg -- shared definitions for the accelerator controller.
//
// Holds the word offsets of the register map and the per-channel state
// type used by accel_ch_fsm. Imported by accel_ch_fsm and accel_ctrl_mc.
//
// Optional feature macro used by the files that import this package:
//   ACCEL_CTRL_TIMEOUT_EN -- enables the per-channel run timeout.

package accel_ctrl_mc_pkg;

  // Register map, word addresses
  localparam int REG_GCTRL    = 0;
  localparam int REG_START    = 1;
  localparam int REG_BUSY     = 2;
  localparam int REG_DONE     = 3;
  localparam int REG_ERR      = 4;
  localparam int REG_IMASK    = 5;
  localparam int REG_TIMEOUT  = 6;
  localparam int REG_ID       = 7;
  localparam int REG_CNT_BASE = 8;

  // Channel state
  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

endpackage

// File: rtl/accel_ch_fsm.sv
// accel_ch_fsm -- one accelerator channel: IDLE/RUN FSM, run-cycle counter
// and (optionally) run timeout.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start_req     : START register write with this channel's bit set
//   done, err     : completion / error pulses from the accelerator
//   timeout       : timeout threshold (0 = disabled)
//   start_pulse   : registered one-cycle start pulse to the accelerator
//   abort_pulse   : registered one-cycle abort pulse on timeout
//   busy          : high while in RUN
//   set_done      : combinational request to set the sticky DONE bit
//   set_err       : combinational request to set the sticky ERR bit
//   cnt           : run-cycle counter, saturating, held in IDLE
//
// Macro: ACCEL_CTRL_TIMEOUT_EN enables the timeout; without it abort_pulse
// is tied low and the timeout input is ignored.

module accel_ch_fsm
  import accel_ctrl_mc_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_req,
  input  logic                 done,
  input  logic                 err,
  input  logic [CNT_WIDTH-1:0] timeout,
  output logic                 start_pulse,
  output logic                 abort_pulse,
  output logic                 busy,
  output logic                 set_done,
  output logic                 set_err,
  output logic [CNT_WIDTH-1:0] cnt
);

  ch_state_t state_q, state_d;
  logic      start_d;
  logic      abort_d;
  logic      timeout_hit;

`ifdef ACCEL_CTRL_TIMEOUT_EN
  assign timeout_hit = (timeout != '0) && (cnt == timeout);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout;
  assign timeout_hit    = 1'b0;
`endif

  assign busy = (state_q == CH_RUN);

  // Next-state logic. Done and error both end the run and may fire together;
  // a timeout only aborts when neither arrived in the same cycle, so a
  // last-moment completion is reported as a success rather than an abort.
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    set_done = 1'b0;
    set_err  = 1'b0;
    case (state_q)
      CH_IDLE: begin
        if (start_req) begin
          state_d = CH_RUN;
          start_d = 1'b1;
        end
      end
      CH_RUN: begin
        set_done = done;
        set_err  = err;
        if (done || err) begin
          state_d = CH_IDLE;
        end else if (timeout_hit) begin
          state_d = CH_IDLE;
          abort_d = 1'b1;
          set_err = 1'b1;
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  // State, start pulse and counter. The counter clears on the same edge that
  // issues the start pulse and then counts every RUN cycle up to all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CH_IDLE;
      start_pulse <= 1'b0;
      cnt         <= '0;
    end else begin
      state_q     <= state_d;
      start_pulse <= start_d;
      if (start_d) begin
        cnt <= '0;
      end else if ((state_q == CH_RUN) && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef ACCEL_CTRL_TIMEOUT_EN
  // Registered abort pulse, coincident with the drop back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abort_pulse <= 1'b0;
    end else begin
      abort_pulse <= abort_d;
    end
  end
`else
  logic unused_abort;
  assign unused_abort = abort_d;
  assign abort_pulse  = 1'b0;
`endif

endmodule

// File: rtl/accel_ctrl_mc.sv
// accel_ctrl_mc -- multi-channel accelerator controller: register file,
// interrupt generation and N_CH instances of accel_ch_fsm.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   cfg_en     : register access request
//   cfg_addr   : word address
//   cfg_we     : 1 = write, 0 = read
//   cfg_be     : byte enables for writes
//   cfg_wdata  : write data
//   cfg_rdata  : read data, registered, valid the cycle after a read
//   ch_start   : one-cycle start pulse per channel
//   ch_done    : per-channel completion pulse
//   ch_err     : per-channel error pulse
//   ch_abort   : one-cycle abort pulse per channel (timeout)
//   irq        : registered level interrupt
//
// Macro: ACCEL_CTRL_TIMEOUT_EN enables the TIMEOUT register and channel
// timeouts; without it TIMEOUT reads 0 and ch_abort stays low.

module accel_ctrl_mc
  import accel_ctrl_mc_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_en,
  input  logic [ADDR_WIDTH-1:0]   cfg_addr,
  input  logic                    cfg_we,
  input  logic [DATA_WIDTH/8-1:0] cfg_be,
  input  logic [DATA_WIDTH-1:0]   cfg_wdata,
  output logic [DATA_WIDTH-1:0]   cfg_rdata,
  output logic [N_CH-1:0]         ch_start,
  input  logic [N_CH-1:0]         ch_done,
  input  logic [N_CH-1:0]         ch_err,
  output logic [N_CH-1:0]         ch_abort,
  output logic                    irq
);

  localparam logic [7:0] ID_NCH = 8'(N_CH);
  localparam logic [7:0] ID_CW  = 8'(CNT_WIDTH);

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] wdata_m;
  logic [DATA_WIDTH-1:0] rd_val;

  logic                  irq_en_q, irq_en_d;
  logic [N_CH-1:0]       imask_q, imask_d;
  logic [N_CH-1:0]       done_q, done_d;
  logic [N_CH-1:0]       err_q, err_d;
  logic [N_CH-1:0]       done_clr, err_clr;
  logic [N_CH-1:0]       start_req;
  logic [N_CH-1:0]       busy;
  logic [N_CH-1:0]       set_done, set_err;
  logic [CNT_WIDTH-1:0]  cnt [N_CH];

`ifdef ACCEL_CTRL_TIMEOUT_EN
  logic [CNT_WIDTH-1:0]  timeout_q, timeout_d;
`else
  logic [CNT_WIDTH-1:0]  timeout_q;
  assign timeout_q = '0;
`endif

  assign wr_en   = cfg_en & cfg_we;
  assign rd_en   = cfg_en & ~cfg_we;
  assign wdata_m = cfg_wdata & wmask;

  // Only the low N_CH / CNT_WIDTH bits of the masked write data land
  // anywhere; the rest are intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = ^wdata_m;

  // Expand byte enables to a per-bit write mask.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      wmask[b] = cfg_be[b/8];
    end
  end

  // Register write decode and next values. Sticky bits OR in the hardware
  // set after applying the W1C clear, so a same-cycle set always wins.
  always_comb begin
    irq_en_d  = irq_en_q;
    imask_d   = imask_q;
    done_clr  = '0;
    err_clr   = '0;
    start_req = '0;
`ifdef ACCEL_CTRL_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    if (wr_en) begin
      case (cfg_addr)
        ADDR_WIDTH'(REG_GCTRL): if (wmask[0]) irq_en_d = cfg_wdata[0];
        ADDR_WIDTH'(REG_START): start_req = wdata_m[N_CH-1:0];
        ADDR_WIDTH'(REG_DONE):  done_clr  = wdata_m[N_CH-1:0];
        ADDR_WIDTH'(REG_ERR):   err_clr   = wdata_m[N_CH-1:0];
        ADDR_WIDTH'(REG_IMASK): imask_d   = (imask_q & ~wmask[N_CH-1:0]) | wdata_m[N_CH-1:0];
`ifdef ACCEL_CTRL_TIMEOUT_EN
        ADDR_WIDTH'(REG_TIMEOUT): timeout_d = (timeout_q & ~wmask[CNT_WIDTH-1:0]) | wdata_m[CNT_WIDTH-1:0];
`endif
        default: ;
      endcase
    end
    done_d = (done_q & ~done_clr) | set_done;
    err_d  = (err_q  & ~err_clr)  | set_err;
  end

  // Read mux over the current (pre-write) register values.
  always_comb begin
    rd_val = '0;
    case (cfg_addr)
      ADDR_WIDTH'(REG_GCTRL):   rd_val[0]        = irq_en_q;
      ADDR_WIDTH'(REG_BUSY):    rd_val[N_CH-1:0] = busy;
      ADDR_WIDTH'(REG_DONE):    rd_val[N_CH-1:0] = done_q;
      ADDR_WIDTH'(REG_ERR):     rd_val[N_CH-1:0] = err_q;
      ADDR_WIDTH'(REG_IMASK):   rd_val[N_CH-1:0] = imask_q;
      ADDR_WIDTH'(REG_TIMEOUT): rd_val           = DATA_WIDTH'(timeout_q);
      ADDR_WIDTH'(REG_ID):      rd_val           = DATA_WIDTH'({ID_NCH, ID_CW});
      default: ;
    endcase
    for (int c = 0; c < N_CH; c++) begin
      if (cfg_addr == ADDR_WIDTH'(REG_CNT_BASE + c)) begin
        rd_val = DATA_WIDTH'(cnt[c]);
      end
    end
  end

  // Register file, read data and interrupt. irq is computed from the next
  // register values so it rises on the same edge the sticky bit is set,
  // i.e. one cycle after the channel's done/err pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q  <= 1'b0;
      imask_q   <= '0;
      done_q    <= '0;
      err_q     <= '0;
      cfg_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      irq_en_q  <= irq_en_d;
      imask_q   <= imask_d;
      done_q    <= done_d;
      err_q     <= err_d;
      if (rd_en) begin
        cfg_rdata <= rd_val;
      end
      irq <= irq_en_d & (|((done_d | err_d) & imask_d));
    end
  end

`ifdef ACCEL_CTRL_TIMEOUT_EN
  // Timeout threshold register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= '0;
    end else begin
      timeout_q <= timeout_d;
    end
  end
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    accel_ch_fsm #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .start_req   (start_req[c]),
      .done        (ch_done[c]),
      .err         (ch_err[c]),
      .timeout     (timeout_q),
      .start_pulse (ch_start[c]),
      .abort_pulse (ch_abort[c]),
      .busy        (busy[c]),
      .set_done    (set_done[c]),
      .set_err     (set_err[c]),
      .cnt         (cnt[c])
    );
  end

endmodule
